// File: rtl/dff_demux_1x2.sv
// dff_demux_1x2: routes one input stream into two independent FIFO channels.
// Each channel is a DEPTH-entry ring buffer with valid/ready on both sides.

module dff_demux_chan #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Status and head word; an empty channel presents all-zero data.
    always_comb begin
        valid = (cnt_q != '0);
        full  = (cnt_q == CW'(DEPTH));
        cnt   = cnt_q;
        dout  = valid ? mem_q[rd_ptr_q] : '0;
    end

    // Next state: write at tail, advance head, pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Register update; reset discards every buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

module dff_demux_1x2 #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       x,
    input  logic                   s,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [WIDTH-1:0]       f1,
    output logic                   f1_valid,
    input  logic                   f1_ready,
    output logic [WIDTH-1:0]       f2,
    output logic                   f2_valid,
    input  logic                   f2_ready,
    output logic [$clog2(DEPTH):0] cnt1,
    output logic [$clog2(DEPTH):0] cnt2
);

    logic full1;
    logic full2;
    logic push1;
    logic push2;
    logic pop1;
    logic pop2;

    // Ready follows only the selected channel; a full channel never
    // accepts, even if it is popping in the same cycle.
    always_comb begin
        x_ready = ~rst & (s ? ~full2 : ~full1);
        push1   = x_valid & x_ready & ~s;
        push2   = x_valid & x_ready & s;
        pop1    = f1_valid & f1_ready & ~rst;
        pop2    = f2_valid & f2_ready & ~rst;
    end

    dff_demux_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   (x),
        .dout  (f1),
        .valid (f1_valid),
        .full  (full1),
        .cnt   (cnt1)
    );

    dff_demux_chan #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2),
        .pop   (pop2),
        .din   (x),
        .dout  (f2),
        .valid (f2_valid),
        .full  (full2),
        .cnt   (cnt2)
    );

endmodule

// File: tb/tb_dff_demux_1x2.sv
// tb_dff_demux_1x2: directed and random stimulus for dff_demux_1x2,
// checked against a queue-based model of the two channels.

module tb_dff_demux_1x2;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  x = '0;
    logic          s = 1'b0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic [W-1:0]  f1;
    logic          f1_valid;
    logic          f1_ready = 1'b0;
    logic [W-1:0]  f2;
    logic          f2_valid;
    logic          f2_ready = 1'b0;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    dff_demux_1x2 #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .s        (s),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .f1       (f1),
        .f1_valid (f1_valid),
        .f1_ready (f1_ready),
        .f2       (f2),
        .f2_valid (f2_valid),
        .f2_ready (f2_ready),
        .cnt1     (cnt1),
        .cnt2     (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: drive, compare visible state, then advance the model.
    task automatic step(input bit r, input bit xv, input bit sel,
                        input logic [W-1:0] xd, input bit r1,
                        input bit r2);
        bit er;
        logic [W-1:0] h1;
        logic [W-1:0] h2;
        @(negedge clk);
        rst      = r;
        x_valid  = xv;
        s        = sel;
        x        = xd;
        f1_ready = r1;
        f2_ready = r2;
        #1;
        er = !r && (sel ? (q2.size() < D) : (q1.size() < D));
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h2 = (q2.size() > 0) ? q2[0] : '0;
        chk("x_ready", 32'(x_ready), 32'(er));
        chk("f1_valid", 32'(f1_valid), 32'(q1.size() > 0));
        chk("f1", 32'(f1), 32'(h1));
        chk("cnt1", 32'(cnt1), 32'(q1.size()));
        chk("f2_valid", 32'(f2_valid), 32'(q2.size() > 0));
        chk("f2", 32'(f2), 32'(h2));
        chk("cnt2", 32'(cnt2), 32'(q2.size()));
        @(posedge clk);
        if (r) begin
            q1.delete();
            q2.delete();
        end else begin
            if (r1 && q1.size() > 0) void'(q1.pop_front());
            if (r2 && q2.size() > 0) void'(q2.pop_front());
            if (xv && er) begin
                if (sel) q2.push_back(xd);
                else     q1.push_back(xd);
            end
        end
    endtask

    initial begin
        // Bring state out of X before any comparison.
        @(posedge clk);

        // Reset held with x_valid high.
        step(1, 1, 0, 4'h1, 0, 0);
        step(1, 1, 1, 4'h1, 1, 1);

        // Routing by s.
        step(0, 1, 0, 4'h1, 0, 0);
        step(0, 1, 1, 4'h1, 0, 0);
        step(0, 1, 0, 4'h0, 0, 0);
        step(0, 0, 1, 4'hf, 0, 0);

        // Fill channel 1, then back-pressure only on s=0.
        step(0, 1, 0, 4'h3, 0, 0);
        step(0, 1, 0, 4'h4, 0, 0);
        step(0, 1, 0, 4'h5, 0, 0);
        step(0, 1, 1, 4'h7, 0, 0);

        // Full channel popping: no write-through, accepts next cycle.
        step(0, 1, 0, 4'h9, 1, 0);
        step(0, 1, 0, 4'ha, 0, 0);
        step(0, 0, 0, 4'h0, 0, 0);

        // Drain both channels.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 4'h0, 1, 1);

        // Ordering and wrap on channel 2 with intermittent ready.
        for (int i = 1; i <= 6; i++)
            step(0, 1, 1, W'(i), 0, (i % 2) == 0);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 4'h0, 0, (i % 2) == 1);

        // Reset mid-stream discards buffered words.
        step(0, 1, 0, 4'hb, 0, 0);
        step(0, 1, 0, 4'hc, 0, 0);
        step(1, 0, 0, 4'h0, 0, 0);
        step(0, 0, 0, 4'h0, 1, 1);
        step(0, 1, 0, 4'hd, 1, 0);
        step(0, 0, 0, 4'h0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, 1'($urandom),
                 1'($urandom), W'($urandom), 1'($urandom),
                 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
